// File: rtl/rgby_pkg.sv
// Shared colour/filter codes and sampler FSM state encoding for the RGBY cell reader.
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
package rgby_pkg;

   // 2-bit colour code handed to the RAM-fill stage
   typedef enum logic [1:0] {
      COLOR_RED    = 2'b00,
      COLOR_GREEN  = 2'b01,
      COLOR_BLUE   = 2'b10,
      COLOR_YELLOW = 2'b11
   } color_t;

   // Sensor {S2,S3} pin codes selecting the photodiode filter
   typedef enum logic [1:0] {
      FILT_RED   = 2'b00,
      FILT_BLUE  = 2'b01,
      FILT_GREEN = 2'b11
   } filter_t;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_SET_R,
      ST_GATE_R,
      ST_SET_G,
      ST_GATE_G,
      ST_SET_B,
      ST_GATE_B,
      ST_CLASSIFY,
      ST_EMIT
   } sampler_state_t;

endpackage

// File: rtl/color_sampler_if.sv
// Bundle of the sampler's request, sensor and result signals.
// Latency: n/a (wires only).
// Backpressure: none; start is a level request, colorReady a one-cycle strobe.
// master: request side (drives start and the sensor line); slave: the sampler.
interface color_sampler_if;
   logic       start;
   logic       sensorFreq;
   logic [1:0] filterSel;
   logic       busy;
   logic       colorReady;
   logic [1:0] color;
   logic       overflow;

   modport master (
      output start, sensorFreq,
      input  filterSel, busy, colorReady, color, overflow
   );

   modport slave (
      input  start, sensorFreq,
      output filterSel, busy, colorReady, color, overflow
   );
endinterface

// File: rtl/color_sampler_pulse_counter.sv
// Synchronises an asynchronous square wave and counts its rising edges, saturating.
// Latency: an input edge reaches the counter 3 clk later (2-FF sync + edge register).
// Backpressure: none; edges arriving while disabled are dropped.
// Ports: clk, reset (sync, active-high), freqIn (async), enable, clear, count, saturated.
module pulse_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             freqIn,
   input  logic             enable,
   input  logic             clear,
   output logic [CNT_W-1:0] count,
   output logic             saturated
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic syncA;
   logic syncB;
   logic syncPrev;
   logic riseEdge;

   assign riseEdge  = syncB && !syncPrev;
   assign saturated = (count == CNT_MAX);

   always_ff @(posedge clk) begin
      if (reset) begin
         syncA    <= 1'b0;
         syncB    <= 1'b0;
         syncPrev <= 1'b0;
         count    <= '0;
      end else begin
         syncA    <= freqIn;
         syncB    <= syncA;
         syncPrev <= syncB;
         if (clear) begin
            count <= '0;
         end else if (enable && riseEdge && !saturated) begin
            // holds at all-ones instead of wrapping
            count <= count + CNT_ONE;
         end
      end
   end

endmodule

// File: rtl/color_sampler.sv
// Reads one RGBY cell from a frequency-output colour sensor per start request.
// Latency: start accepted in cycle T -> colorReady in T + 3*(SETTLE_CYCLES+GATE_CYCLES) + 2.
// Backpressure: none; start is ignored unless idle, results are a one-cycle strobe.
// Ports: clk, reset (sync, active-high), bus (slave): start, sensorFreq in;
//        filterSel, busy, colorReady, color, overflow out.
module color_sampler #(
   parameter int GATE_CYCLES   = 50000,
   parameter int SETTLE_CYCLES = 5000,
   parameter int CNT_W         = 16
) (
   input  logic            clk,
   input  logic            reset,
   color_sampler_if.slave  bus
);

   import rgby_pkg::*;

   // One timer serves both SET and GATE phases; sized to hold the longer one.
   localparam int TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
   localparam logic [TMR_W-1:0] GATE_LAST   = TMR_W'(GATE_CYCLES - 1);
   localparam logic [TMR_W-1:0] TMR_ONE     = TMR_W'(1);

   // Two guard bits so 3*x and 4*x of a full-scale count still fit.
   localparam int AW = CNT_W + 2;

   sampler_state_t   state;
   sampler_state_t   stateNext;
   logic [TMR_W-1:0] timer;

   logic             startAccept;
   logic             enR;
   logic             enG;
   logic             enB;
   filter_t          filt;
   logic             readyStrobe;

   logic [CNT_W-1:0] cntR;
   logic [CNT_W-1:0] cntG;
   logic [CNT_W-1:0] cntB;
   logic             satR;
   logic             satG;
   logic             satB;

   logic [1:0]       colorReg;
   logic             overflowReg;
   color_t           classColor;

   logic [AW-1:0]    r;
   logic [AW-1:0]    g;
   logic [AW-1:0]    b;
   logic [AW-1:0]    r3;
   logic [AW-1:0]    g3;
   logic [AW-1:0]    r4;
   logic [AW-1:0]    g4;

   // ---------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= stateNext;
      end
   end

   always_comb begin
      stateNext   = state;
      startAccept = 1'b0;
      enR         = 1'b0;
      enG         = 1'b0;
      enB         = 1'b0;
      filt        = FILT_RED;
      readyStrobe = 1'b0;

      case (state)
         ST_IDLE: begin
            if (bus.start) begin
               startAccept = 1'b1;
               stateNext   = ST_SET_R;
            end
         end
         ST_SET_R: begin
            filt = FILT_RED;
            if (timer == SETTLE_LAST) stateNext = ST_GATE_R;
         end
         ST_GATE_R: begin
            filt = FILT_RED;
            enR  = 1'b1;
            if (timer == GATE_LAST) stateNext = ST_SET_G;
         end
         ST_SET_G: begin
            filt = FILT_GREEN;
            if (timer == SETTLE_LAST) stateNext = ST_GATE_G;
         end
         ST_GATE_G: begin
            filt = FILT_GREEN;
            enG  = 1'b1;
            if (timer == GATE_LAST) stateNext = ST_SET_B;
         end
         ST_SET_B: begin
            filt = FILT_BLUE;
            if (timer == SETTLE_LAST) stateNext = ST_GATE_B;
         end
         ST_GATE_B: begin
            filt = FILT_BLUE;
            enB  = 1'b1;
            if (timer == GATE_LAST) stateNext = ST_CLASSIFY;
         end
         ST_CLASSIFY: begin
            stateNext = ST_EMIT;
         end
         ST_EMIT: begin
            readyStrobe = 1'b1;
            stateNext   = ST_IDLE;
         end
         default: begin
            stateNext = ST_IDLE;
         end
      endcase
   end

   // Phase timer restarts on every state change so each SET/GATE phase
   // runs for exactly its programmed number of cycles.
   always_ff @(posedge clk) begin
      if (reset || (stateNext != state) || (state == ST_IDLE)) begin
         timer <= '0;
      end else begin
         timer <= timer + TMR_ONE;
      end
   end

   // ---------------------------------------------------------------
   // Per-channel edge counters; cleared on an accepted start and held
   // afterwards so the classifier sees all three totals together.
   // ---------------------------------------------------------------
   pulse_counter #(.CNT_W(CNT_W)) u_cntR (
      .clk       (clk),
      .reset     (reset),
      .freqIn    (bus.sensorFreq),
      .enable    (enR),
      .clear     (startAccept),
      .count     (cntR),
      .saturated (satR)
   );

   pulse_counter #(.CNT_W(CNT_W)) u_cntG (
      .clk       (clk),
      .reset     (reset),
      .freqIn    (bus.sensorFreq),
      .enable    (enG),
      .clear     (startAccept),
      .count     (cntG),
      .saturated (satG)
   );

   pulse_counter #(.CNT_W(CNT_W)) u_cntB (
      .clk       (clk),
      .reset     (reset),
      .freqIn    (bus.sensorFreq),
      .enable    (enB),
      .clear     (startAccept),
      .count     (cntB),
      .saturated (satB)
   );

   // ---------------------------------------------------------------
   // Classification; first matching rule wins.
   // ---------------------------------------------------------------
   always_comb begin
      r  = {2'b00, cntR};
      g  = {2'b00, cntG};
      b  = {2'b00, cntB};
      r4 = {r[AW-3:0], 2'b00};
      g4 = {g[AW-3:0], 2'b00};
      r3 = r + {r[AW-2:0], 1'b0};
      g3 = g + {g[AW-2:0], 1'b0};

      classColor = COLOR_GREEN;
      if ((b >= r) && (b >= g)) begin
         classColor = COLOR_BLUE;                // ties resolve to blue
      end else if ((g4 >= r3) && (r4 >= g3) && (r > b) && (g > b)) begin
         classColor = COLOR_YELLOW;              // R and G within 3:4 of each other
      end else if (r >= g) begin
         classColor = COLOR_RED;
      end
   end

   // Result is latched at the end of CLASSIFY so it is stable for the
   // whole EMIT (strobe) cycle and held until the next strobe.
   always_ff @(posedge clk) begin
      if (reset) begin
         colorReg <= 2'b00;
      end else if (state == ST_CLASSIFY) begin
         colorReg <= classColor;
      end
   end

   // Overflow is sticky for the sample; the start clear takes priority
   // over the stale saturation flags of the previous sample.
   always_ff @(posedge clk) begin
      if (reset) begin
         overflowReg <= 1'b0;
      end else if (startAccept) begin
         overflowReg <= 1'b0;
      end else if (satR || satG || satB) begin
         overflowReg <= 1'b1;
      end
   end

   assign bus.filterSel  = filt;
   assign bus.busy       = (state != ST_IDLE);
   assign bus.colorReady = readyStrobe;
   assign bus.color      = colorReg;
   assign bus.overflow   = overflowReg;

endmodule

// File: tb/tb_color_sampler.sv
module tb_color_sampler;

   localparam int GATE    = 100;
   localparam int SETTLE  = 10;
   localparam int LAT     = 1 + 3 * (SETTLE + GATE) + 1;   // 332
   localparam int SPACING = LAT + 1;                       // 333

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   color_sampler_if bus8();
   color_sampler_if bus4();

   color_sampler #(.GATE_CYCLES(GATE), .SETTLE_CYCLES(SETTLE), .CNT_W(8)) u_dut8 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus8.slave)
   );

   color_sampler #(.GATE_CYCLES(GATE), .SETTLE_CYCLES(SETTLE), .CNT_W(4)) u_dut4 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus4.slave)
   );

   int checks = 0;
   int errors = 0;

   // sensor period (clk cycles) per filterSel code: [0]=red [1]=blue [3]=green
   int per8[4] = '{20, 20, 20, 20};
   int per4[4] = '{20, 20, 20, 20};
   int ph8 = 0;
   int ph4 = 0;
   int p8;
   int p4;

   logic useDut4 = 1'b0;
   logic [1:0] mFilt;
   logic [1:0] mColor;
   logic       mBusy;
   logic       mReady;
   logic       mOv;

   assign mFilt  = useDut4 ? bus4.filterSel  : bus8.filterSel;
   assign mColor = useDut4 ? bus4.color      : bus8.color;
   assign mBusy  = useDut4 ? bus4.busy       : bus8.busy;
   assign mReady = useDut4 ? bus4.colorReady : bus8.colorReady;
   assign mOv    = useDut4 ? bus4.overflow   : bus8.overflow;

   // Sensor models: square wave whose period follows the selected filter.
   initial begin
      bus8.sensorFreq = 1'b0;
      forever begin
         @(negedge clk);
         p8 = per8[bus8.filterSel];
         if (ph8 >= p8 - 1) ph8 = 0; else ph8++;
         bus8.sensorFreq = (ph8 < p8 / 2);
      end
   end

   initial begin
      bus4.sensorFreq = 1'b0;
      forever begin
         @(negedge clk);
         p4 = per4[bus4.filterSel];
         if (ph4 >= p4 - 1) ph4 = 0; else ph4++;
         bus4.sensorFreq = (ph4 < p4 / 2);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic setStart(input logic v);
      if (useDut4) bus4.start = v; else bus8.start = v;
   endtask

   task automatic setPeriods(input int pr, input int pg, input int pb);
      if (useDut4) begin
         per4[0] = pr; per4[1] = pb; per4[2] = 20; per4[3] = pg;
      end else begin
         per8[0] = pr; per8[1] = pb; per8[2] = 20; per8[3] = pg;
      end
   endtask

   // Called on a negedge; start is raised now (cycle T = j 0) and the
   // outputs are observed on each following negedge (cycle T+j).
   task automatic runSample(input string tag, input logic [1:0] expColor,
                            input logic expOv, input int restartAt);
      int hit;
      int nReady;
      hit = -1;
      nReady = 0;
      setStart(1'b1);
      for (int j = 1; j <= LAT + 200; j++) begin
         @(negedge clk);
         if (mReady) begin
            nReady++;
            if (hit < 0) hit = j;
         end
         if (j == 1) begin
            check({tag, "_busy_T1"}, 32'(mBusy), 1);
            check({tag, "_ovclr_T1"}, 32'(mOv), 0);
            check({tag, "_filt_setR"}, 32'(mFilt), 0);
         end
         if (j == 110) check({tag, "_filt_gateR_end"}, 32'(mFilt), 0);
         if (j == 111) check({tag, "_filt_setG"}, 32'(mFilt), 3);
         if (j == 221) check({tag, "_filt_setB"}, 32'(mFilt), 1);
         if (j == LAT) begin
            check({tag, "_color"}, 32'(mColor), 32'(expColor));
            check({tag, "_overflow"}, 32'(mOv), 32'(expOv));
            check({tag, "_busy_emit"}, 32'(mBusy), 1);
         end
         if (j == LAT + 1) begin
            check({tag, "_busy_after"}, 32'(mBusy), 0);
            check({tag, "_filt_after"}, 32'(mFilt), 0);
            check({tag, "_color_held"}, 32'(mColor), 32'(expColor));
         end
         if (j == 1) setStart(1'b0);
         if (j == restartAt) setStart(1'b1);
         if (j == restartAt + 1) setStart(1'b0);
      end
      check({tag, "_latency"}, 32'(hit), 32'(LAT));
      check({tag, "_strobes"}, 32'(nReady), 1);
   endtask

   initial begin
      int first;
      int second;
      int nReady;

      bus8.start = 1'b0;
      bus4.start = 1'b0;
      reset = 1'b1;
      repeat (3) @(negedge clk);

      // reset state
      check("rst_filt", 32'(bus8.filterSel), 0);
      check("rst_busy", 32'(bus8.busy), 0);
      check("rst_ready", 32'(bus8.colorReady), 0);
      check("rst_color", 32'(bus8.color), 0);
      check("rst_ovf", 32'(bus8.overflow), 0);
      check("rst_cntR", 32'(u_dut8.u_cntR.count), 0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // red 25/5/5 -> 00
      setPeriods(4, 20, 20);
      runSample("red", 2'b00, 1'b0, -1);
      // yellow 25/25/5 -> 11
      setPeriods(4, 4, 20);
      runSample("yellow", 2'b11, 1'b0, -1);
      // green 5/25/5 -> 01
      setPeriods(20, 4, 20);
      runSample("green", 2'b01, 1'b0, -1);
      // blue tie 25/5/25 -> 10
      setPeriods(4, 20, 4);
      runSample("bluetie", 2'b10, 1'b0, -1);
      // second start while busy is ignored
      setPeriods(4, 20, 20);
      runSample("busystart", 2'b00, 1'b0, 50);

      // back-to-back: start held high, second accepted in the idle cycle
      first = -1; second = -1; nReady = 0;
      setStart(1'b1);
      for (int j = 1; j <= 2 * LAT + 40; j++) begin
         @(negedge clk);
         if (mReady) begin
            nReady++;
            if (first < 0) first = j; else if (second < 0) second = j;
         end
         if (j == LAT + 1) check("b2b_busy_gap", 32'(mBusy), 0);
         if (j == LAT + 2) setStart(1'b0);
      end
      check("b2b_first", 32'(first), 32'(LAT));
      check("b2b_spacing", 32'(second - first), 32'(SPACING));
      check("b2b_strobes", 32'(nReady), 2);

      // reset in the middle of GATE_G
      nReady = 0;
      setStart(1'b1);
      for (int j = 1; j <= LAT + 100; j++) begin
         @(negedge clk);
         if (mReady) nReady++;
         if (j == 1) setStart(1'b0);
         if (j == 150) begin
            check("rstmid_in_gateG", 32'(mFilt), 3);
            reset = 1'b1;
         end
         if (j == 151) begin
            check("rstmid_filt", 32'(mFilt), 0);
            check("rstmid_busy", 32'(mBusy), 0);
            reset = 1'b0;
         end
      end
      check("rstmid_no_strobe", 32'(nReady), 0);
      setPeriods(20, 4, 20);
      runSample("after_rst", 2'b01, 1'b0, -1);

      // saturation on the 4-bit instance: 50 red edges -> holds 15
      useDut4 = 1'b1;
      @(negedge clk);
      setPeriods(2, 20, 20);
      runSample("ovf", 2'b00, 1'b1, -1);
      check("ovf_cntR_sat", 32'(u_dut4.u_cntR.count), 15);
      // clean sample (10/5/5) clears overflow
      setPeriods(10, 20, 20);
      runSample("clean", 2'b00, 1'b0, -1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // absolute bound so the run always ends
   initial begin
      #2000000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
